// File: rtl/link_pkg.sv
// link_pkg: shared constants and helpers for the TDM serial link.
package link_pkg;
    localparam int N_DEF   = 8;
    localparam int SEL_DEF = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: modulo-N slot counter with load-to-0/1 and terminal-count flag.
module mod_n_counter
    import link_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = SEL_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         ld0,
    input  logic         ld1,
    output logic [W-1:0] cnt,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == W'(N - 1));

    // load-to-1 covers a realigning valid bit already written to slot 0
    always_comb begin
        cnt_d = ld1 ? W'(1) :
                ld0 ? '0 :
                en  ? (tc ? '0 : cnt_q + 1'b1) :
                      cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tdm_demux_deser.sv
// tdm_demux_deser: 1xN TDM demultiplexer/deserializer presenting words on valid/ready.
module tdm_demux_deser
    import link_pkg::*;
#(
    parameter int N   = N_DEF,
    parameter int SEL = SEL_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           din,
    input  logic           din_valid,
    input  logic           frame_start,
    output logic [N-1:0]   dout,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [SEL-1:0] sel_cnt,
    output logic           overrun,
    input  logic           clr_overrun
);
    if (N < 2)              $error("tdm_demux_deser: N must be >= 2");
    if (SEL < clog2(N))     $error("tdm_demux_deser: SEL too narrow for N");

    logic [N-1:0] asm_q, asm_d;
    logic [N-1:0] dout_q, dout_d;
    logic         dout_valid_q, dout_valid_d;
    logic         overrun_q, overrun_d;
    logic         tc, complete, can_load;
    logic [N-1:0] word;

    mod_n_counter #(.N(N), .W(SEL)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (din_valid),
        .ld0   (frame_start & ~din_valid),
        .ld1   (frame_start & din_valid),
        .cnt   (sel_cnt),
        .tc    (tc)
    );

    always_comb begin
        asm_d = asm_q;
        if (din_valid) asm_d[frame_start ? SEL'(0) : sel_cnt] = din;
        complete     = din_valid & ~frame_start & tc;
        word         = {din, asm_q[N-2:0]};
        // a finished word may only replace dout once the old one is gone or leaving
        can_load     = ~dout_valid_q | dout_ready;
        dout_d       = (complete & can_load) ? word : dout_q;
        dout_valid_d = (complete & can_load) ? 1'b1 :
                       (dout_valid_q & dout_ready) ? 1'b0 : dout_valid_q;
        overrun_d    = (complete & ~can_load) | (overrun_q & ~clr_overrun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            asm_q        <= asm_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_tdm_demux_deser.sv
// tb_tdm_demux_deser: random + directed checks of N=8 and N=5 instances against a queue model.
module tb_tdm_demux_deser;
    logic       clk = 0, rst_n = 0;
    logic       din = 0, din_valid = 0, frame_start = 0, dout_ready = 0, clr_overrun = 0;
    logic [7:0] dout8;
    logic [4:0] dout5;
    logic [2:0] sel8, sel5;
    logic       dv8, dv5, ov8, ov5;
    int         n_tests = 0, n_fail = 0;

    bit         mq[2][$];
    logic [7:0] md[2];
    logic       mv[2], mo[2];
    int         nw[2] = '{8, 5};

    always #5 clk = ~clk;

    tdm_demux_deser #(.N(8), .SEL(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .dout(dout8), .dout_valid(dv8), .dout_ready(dout_ready), .sel_cnt(sel8),
        .overrun(ov8), .clr_overrun(clr_overrun)
    );

    tdm_demux_deser #(.N(5), .SEL(3)) dut5 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .frame_start(frame_start),
        .dout(dout5), .dout_valid(dv5), .dout_ready(dout_ready), .sel_cnt(sel5),
        .overrun(ov5), .clr_overrun(clr_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            md[i] = '0;
            mv[i] = 0;
            mo[i] = 0;
        end
    endtask

    task automatic check_all();
        chk("dout8", 32'(dout8), 32'(md[0]));
        chk("dv8", 32'(dv8), 32'(mv[0]));
        chk("sel8", 32'(sel8), 32'(mq[0].size()));
        chk("ov8", 32'(ov8), 32'(mo[0]));
        chk("dout5", 32'(dout5), 32'(md[1]));
        chk("dv5", 32'(dv5), 32'(mv[1]));
        chk("sel5", 32'(sel5), 32'(mq[1].size()));
        chk("ov5", 32'(ov5), 32'(mo[1]));
    endtask

    // model: collect bits in a queue; a full queue is a word, bit k = k-th bit received
    task automatic step(input logic d, input logic v, input logic fs, input logic r, input logic c);
        din = d; din_valid = v; frame_start = fs; dout_ready = r; clr_overrun = c;
        for (int i = 0; i < 2; i++) begin
            bit         comp = 0;
            bit         room = !mv[i] || r;
            logic [7:0] w = '0;
            if (fs) mq[i].delete();
            if (v) begin
                mq[i].push_back(d);
                if (mq[i].size() == nw[i]) begin
                    for (int k = 0; k < nw[i]; k++) w[k] = mq[i][k];
                    mq[i].delete();
                    comp = 1;
                end
            end
            if (c) mo[i] = 0;
            if (comp && room) begin
                md[i] = w;
                mv[i] = 1;
            end else begin
                if (mv[i] && r) mv[i] = 0;
                if (comp) mo[i] = 1;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic frame(input logic [7:0] w, input bit gap, input logic r);
        for (int k = 0; k < 8; k++) begin
            step(w[k], 1, k == 0, r, 0);
            if (gap) step(0, 0, 0, r, 0);
        end
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        rst_n = 1;
        @(posedge clk); #1;

        frame(8'hCD, 0, 1);
        chk("basic_word", 32'(dout8), 32'hCD);
        chk("basic_valid", 32'(dv8), 1);
        step(0, 0, 0, 1, 0);
        chk("basic_pulse", 32'(dv8), 0);

        frame(8'hCD, 1, 1);
        chk("gap_word", 32'(dout8), 32'hCD);

        step(0, 0, 1, 0, 0);
        frame(8'hCD, 0, 0);
        frame(8'h3A, 0, 0);
        chk("bp_hold", 32'(dout8), 32'hCD);
        chk("bp_ovr", 32'(ov8), 1);
        step(0, 0, 0, 1, 0);
        chk("bp_drain", 32'(dv8), 0);
        chk("bp_sticky", 32'(ov8), 1);
        step(0, 0, 0, 0, 1);
        chk("bp_clr", 32'(ov8), 0);

        frame(8'hCD, 0, 1);
        chk("b2b_first", 32'(dout8), 32'hCD);
        frame(8'h3A, 0, 1);
        chk("b2b_second", 32'(dout8), 32'h3A);
        step(0, 0, 0, 1, 0);

        step(1, 1, 1, 1, 0);
        step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        chk("realign_none", 32'(dv8), 0);
        frame(8'hA5, 0, 1);
        chk("realign_word", 32'(dout8), 32'hA5);

        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(1, 1, k == 0, 0, 0);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        chk("rst_dout", 32'(dout8), 0);
        chk("rst_dv", 32'(dv8), 0);
        chk("rst_sel", 32'(sel8), 0);
        chk("rst_ov", 32'(ov8), 0);
        chk("rst_sel5", 32'(sel5), 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        frame(8'hFF, 0, 1);
        chk("post_rst_word", 32'(dout8), 32'hFF);

        step(0, 0, 1, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 0, 1, 0);
        chk("n5_at4", 32'(sel5), 4);
        step(1, 1, 0, 1, 0);
        chk("n5_wrap", 32'(sel5), 0);
        chk("n5_word", 32'(dout5), 32'h1F);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
